// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path (and the future RX path).
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;
    localparam int   DATA_BITS    = 8;
    localparam int   DEF_BAUD_DIV = 434;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; a push while full is
// accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             wr_en, rd_en;

    assign rd_en = pop_i && !empty_q;
    assign wr_en = push_i && (!full_q || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !rd_en) count_d = count_q + (AW+1)'(1);
        if (!wr_en && rd_en) count_d = count_q - (AW+1)'(1);
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; frames run back-to-back while
// bytes are queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEF_BAUD_DIV,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = DATA_BITS
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              fifo_full_o,
    output logic              fifo_empty_o,
    output logic              overflow_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_W);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic              bit_end, pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (valid_i),
        .pop_i   (pop),
        .din_i   (data_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end = (state_q != IDLE) && (baud_cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        pop        = 1'b0;
        baud_cnt_d = (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + CW'(1);
        overflow_d = valid_i && fifo_full && !pop;
        case (state_q)
            IDLE: begin
                tx_d = STOP_BIT;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    tx_d      = START_BIT;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == BW'(DATA_W - 1)) begin
                        tx_d    = STOP_BIT;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        tx_d      = START_BIT;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // pop is final here, so a full FIFO being drained this edge absorbs the write
        overflow_d = valid_i && fifo_full && !pop;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= STOP_BIT;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);
    assign fifo_full_o  = fifo_full;
    assign fifo_empty_o = fifo_empty;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=4; sample index k
// holds the outputs just after clock edge k of the current scenario.
module tb_uart_tx_fifo;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       tx_o, busy_o, fifo_full_o, fifo_empty_o, overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    logic tx_s[$], busy_s[$], full_s[$], empty_s[$], ovf_s[$];

    uart_tx_fifo #(
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4),
        .DATA_W     (8)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        tx_s.push_back(tx_o);
        busy_s.push_back(busy_o);
        full_s.push_back(fifo_full_o);
        empty_s.push_back(fifo_empty_o);
        ovf_s.push_back(overflow_o);
    endtask

    task automatic clr();
        tx_s.delete();
        busy_s.delete();
        full_s.delete();
        empty_s.delete();
        ovf_s.delete();
    endtask

    function automatic int ones(input logic q[$], input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    // Line bits sampled mid-bit; bit 0 is the start bit, bit 9 the stop bit.
    function automatic logic [9:0] frame_at(input int base);
        logic [9:0] f;
        for (int b = 0; b < 10; b++) f[b] = tx_s[base + 4*b + 2];
        return f;
    endfunction

    initial begin
        logic [7:0] exp_bytes [6];
        exp_bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};

        arst_i  = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) step();
        chk("rst_tx",    tx_o,         1);
        chk("rst_busy",  busy_o,       0);
        chk("rst_full",  fifo_full_o,  0);
        chk("rst_empty", fifo_empty_o, 1);
        chk("rst_ovf",   overflow_o,   0);
        arst_i = 1'b0;
        repeat (2) step();

        // single byte 0xA5
        clr();
        valid_i = 1'b1; data_i = 8'hA5;
        step();
        valid_i = 1'b0;
        repeat (44) step();
        chk("s_empty_e0",  empty_s[0], 0);
        chk("s_tx_e0",     tx_s[0], 1);
        chk("s_start_e1",  tx_s[1], 0);
        chk("s_frame",     frame_at(1), {1'b1, 8'hA5, 1'b0});
        chk("s_busy_cnt",  ones(busy_s, 0, 44), 40);
        chk("s_busy_e40",  busy_s[40], 1);
        chk("s_busy_e41",  busy_s[41], 0);
        chk("s_end_empty", empty_s[44], 1);

        // back-to-back 0x00, 0xFF
        clr();
        valid_i = 1'b1; data_i = 8'h00; step();
        data_i = 8'hFF; step();
        valid_i = 1'b0;
        repeat (83) step();
        chk("b_frame0",   frame_at(1),  {1'b1, 8'h00, 1'b0});
        chk("b_frame1",   frame_at(41), {1'b1, 8'hFF, 1'b0});
        chk("b_busy_cnt", ones(busy_s, 0, 84), 80);
        chk("b_idle_tx",  ones(tx_s, 81, 84), 4);

        // overflow, then push at full coinciding with the stop-bit pop
        clr();
        for (int c = 0; c < 250; c++) begin
            if (c < 6) begin
                valid_i = 1'b1; data_i = 8'h11 + 8'(c);
            end else if (c == 41) begin
                valid_i = 1'b1; data_i = 8'h17;
            end else begin
                valid_i = 1'b0;
            end
            step();
        end
        valid_i = 1'b0;
        chk("o_full_e3",  full_s[3], 0);
        chk("o_full_e4",  full_s[4], 1);
        chk("o_ovf_e5",   ovf_s[5], 1);
        chk("o_ovf_cnt",  ones(ovf_s, 0, 249), 1);
        chk("o_full_e41", full_s[41], 1);
        chk("o_ovf_e41",  ovf_s[41], 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("o_frame%0d", k), frame_at(1 + 40*k), {1'b1, exp_bytes[k], 1'b0});
        chk("o_busy_cnt", ones(busy_s, 0, 249), 240);
        chk("o_end_empty", empty_s[249], 1);

        // reset during data bit 3 of 0x3C with two bytes queued
        clr();
        valid_i = 1'b1; data_i = 8'h3C; step();
        data_i = 8'hAA; step();
        data_i = 8'h55; step();
        valid_i = 1'b0;
        repeat (17) step();
        chk("r_queued",  empty_s[19], 0);
        chk("r_bit1",    tx_s[10], 0);
        chk("r_bit2",    tx_s[14], 1);
        chk("r_busy",    busy_s[19], 1);
        arst_i = 1'b1;
        #1;
        chk("r_tx",      tx_o, 1);
        chk("r_busy0",   busy_o, 0);
        chk("r_empty",   fifo_empty_o, 1);
        repeat (3) step();
        arst_i = 1'b0;
        clr();
        repeat (60) step();
        chk("r_after_tx",   ones(tx_s, 0, 59), 60);
        chk("r_after_busy", ones(busy_s, 0, 59), 0);

        // idle stability
        clr();
        repeat (100) step();
        chk("i_tx",   ones(tx_s, 0, 99), 100);
        chk("i_busy", ones(busy_s, 0, 99), 0);
        chk("i_ovf",  ones(ovf_s, 0, 99), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
